// File: rtl/nibble_demux.sv
// rtl/nibble_demux.sv - reassembles A/B nibble phases from a muxed bus into bytes behind a small FWFT FIFO
module nibble_demux #(
    parameter int SETTLE = 1,
    parameter int DEPTH  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       g_i,
    input  logic       sela_i,
    input  logic [3:0] y_i,
    input  logic       rd_i,
    input  logic       clr_err_i,
    output logic [7:0] q_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       ovf_o,
    output logic [3:0] perr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0]  SETTLE_C = 4'(SETTLE);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);

    localparam logic [0:0] WAIT_A = 1'b0;
    localparam logic [0:0] WAIT_B = 1'b1;

    logic [3:0]    run_q, run_d;
    logic          prev_sela_q;
    logic          prev_g_q;
    logic [0:0]    state_q, state_d;
    logic [3:0]    hi_q, hi_d;
    logic [3:0]    perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];

    logic load;
    logic capture;
    logic push;
    logic perr_inc;
    logic pop;
    logic push_ok;
    logic ovf_set;
    logic empty;
    logic full;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Run-length of the current phase and the single-cycle capture strobe
    always_comb begin
        load = g_i && ((sela_i != prev_sela_q) || !prev_g_q);
        if (!g_i) begin
            run_d = 4'd0;
        end else if (load) begin
            run_d = 4'd1;
        end else if (run_q == 4'hF) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 4'd1;
        end
        // run_q already at SETTLE means this phase has captured (saturation case)
        capture = g_i && (run_d == SETTLE_C) && (load || (run_q != SETTLE_C));
    end

    // Phase sequencing: pair an A capture with the following B capture
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        push     = 1'b0;
        perr_inc = 1'b0;
        if (!g_i) begin
            state_d = WAIT_A;
        end else if (capture) begin
            case (state_q)
                WAIT_A: begin
                    if (sela_i) begin
                        hi_d    = y_i;
                        state_d = WAIT_B;
                    end else begin
                        perr_inc = 1'b1;
                    end
                end
                default: begin
                    if (sela_i) begin
                        perr_inc = 1'b1;
                        hi_d     = y_i;
                    end else begin
                        push    = 1'b1;
                        state_d = WAIT_A;
                    end
                end
            endcase
        end
    end

    // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        pop      = rd_i && !empty;
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Debug flags; a fresh error in the clear cycle survives the clear
    always_comb begin
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_err_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (clr_err_i) begin
            perr_d = perr_inc ? 4'd1 : 4'd0;
        end else if (perr_inc && (perr_q != 4'hF)) begin
            perr_d = perr_q + 4'd1;
        end else begin
            perr_d = perr_q;
        end
    end

    // Control and status registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q       <= 4'd0;
            prev_sela_q <= 1'b0;
            prev_g_q    <= 1'b0;
            state_q     <= WAIT_A;
            hi_q        <= 4'd0;
            perr_q      <= 4'd0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            run_q       <= run_d;
            prev_sela_q <= sela_i;
            prev_g_q    <= g_i;
            state_q     <= state_d;
            hi_q        <= hi_d;
            perr_q      <= perr_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Word storage; contents are only visible through a non-zero count
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {hi_q, y_i};
        end
    end

    assign q_o     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign full_o  = full;
    assign ovf_o   = ovf_q;
    assign perr_o  = perr_q;

endmodule

// File: doc/nibble_demux.md
# nibble_demux

Receive-side counterpart of the quad 2-input multiplexer: it samples a time-multiplexed 4-bit bus, and each bus phase is identified by the mux select. It reassembles A/B nibble pairs into 8-bit words and buffers them in a small first-word-fall-through FIFO for a synchronous consumer. It sits between an LS157-style muxed bus (G, SELA, Y) and downstream System86 logic that needs whole bytes. Phase-sequence errors and FIFO overflow are flagged for debug.

## Interface
- SETTLE, 1: consecutive stable samples required per phase before capture; legal range 1..15.
- DEPTH, 2: FIFO depth in words; power of two, at least 2.
- CLK  input  1  system clock; all sampling on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- G  input  1  bus enable as driven to the mux; low means the bus is idle (forced 0).
- SELA  input  1  phase select; 1 = A nibble (high nibble), 0 = B nibble (low nibble).
- Y  input  4  multiplexed nibble bus.
- RD  input  1  pop request; ignored when EMPTY.
- Q  output  8  FIFO head word, {A,B}; 8'h00 when EMPTY.
- EMPTY  output  1  FIFO holds no words.
- FULL  output  1  FIFO holds DEPTH words.
- OVF  output  1  sticky; set when a completed word is dropped.
- PERR  output  4  saturating phase-error count (stops at 15).
- CLR_ERR  input  1  synchronous clear of OVF and PERR.

## Operation
- Run counter: a 4-bit counter that saturates at 15.
  - Forced to 0 on any cycle with G=0.
  - On a G=1 cycle where SELA differs from the previous sampled SELA, or the previous cycle had G=0, it loads 1.
  - Otherwise it increments.
- Capture: a nibble is captured on the single cycle where G=1 and the run count after update equals SETTLE. A phase held longer than SETTLE captures exactly once.
- FSM has two states, WAIT_A (reset state) and WAIT_B.
  - WAIT_A, A capture: HI <= Y, go to WAIT_B.
  - WAIT_A, B capture: PERR += 1, stay in WAIT_A.
  - WAIT_B, B capture: push {HI,Y}, go to WAIT_A.
  - WAIT_B, A capture: PERR += 1, HI <= Y (newest A wins), stay in WAIT_B.
  - WAIT_B, G=0: abort the partial word, go to WAIT_A, no error.
- FIFO push/pop rules:
  - Push when FULL with no pop in the same cycle: the word is dropped and OVF is set.
  - Push and pop in the same cycle when FULL: both happen; no overflow, and the count is unchanged.
  - Push and pop in the same cycle when EMPTY: the push happens and the pop is ignored.
  - Pointers wrap modulo DEPTH.
- Error clear: CLR_ERR zeroes OVF and PERR. If a new error occurs in the same cycle, the new error wins: OVF reads 1, PERR reads 1.
- Reset values: FSM in WAIT_A, run counter 0, HI 0, pointers 0, Q 8'h00, EMPTY 1, FULL 0, OVF 0, PERR 0.
- RST asserted mid-word or mid-FIFO discards all contents immediately, with no outputs glitching to non-reset values.

## Timing
- All inputs are sampled at the rising edge of CLK.
- SETTLE=1:
  - A sampled at edge n, B at edge n+1: the word is written at edge n+1.
  - EMPTY falls and Q is valid in the cycle after edge n+1.
  - Latency is one edge from the B sample.
- General SETTLE: the capture edge is the SETTLE-th consecutive stable sample of each phase. The minimum word period is 2*SETTLE cycles.
- Pop: RD high at edge m with EMPTY low advances the head. Q shows the next word (or 8'h00) after edge m.
- EMPTY, FULL, Q, OVF and PERR are registered or derived from registers only. There is no combinational path from inputs to outputs.
- Maximum throughput is one word per 2*SETTLE cycles; RD may be held high continuously.

## Test plan
- Reset and single word:
  - Stimulus: SETTLE=1; assert RST; then G=1, SELA=1 Y=4'hA for one cycle, then SELA=0 Y=4'h5.
  - Response: Q=8'h00 and EMPTY=1 during reset. Q=8'hA5 and EMPTY=0 one cycle after the B sample. RD for one cycle gives EMPTY=1 and Q=8'h00.
- Settle filtering:
  - Stimulus: SETTLE=3; A phase Y=4'h3 held 5 cycles, then B phase Y=4'hC held 3 cycles.
  - Response: exactly one word, 8'h3C. A B phase held only 2 cycles produces no word.
- Phase errors:
  - Stimulus: B, then A=4'h1, then A=4'h2, then B=4'hF.
  - Response: PERR=2 and a single word 8'h2F. Asserting CLR_ERR gives PERR=0.
- Overflow and simultaneous push/pop:
  - Stimulus: DEPTH=2; push 3 words without RD; then push while RD=1 with the FIFO full.
  - Response: the third word is dropped and OVF=1. The fourth push is accepted and FULL stays 1.
  - Order: Q pops words 1, 2, 4.
- Abort and mid-operation reset:
  - Stimulus: A=4'h7, then G=0 for 1 cycle, then B=4'h9.
  - Response: no word and PERR=1, because the B capture arrives in WAIT_A.
  - Stimulus: RST pulsed asynchronously between clock edges while the FIFO holds 1 word.
  - Response: outputs go immediately to EMPTY=1, Q=8'h00.
- Continuous stream:
  - Stimulus: 16 alternating A/B pairs with values 8'h00..8'hFF stride 8'h11, and RD held high.
  - Response: every word appears in order, OVF=0, PERR=0.
